// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-stage types: datapath widths, fetch FSM states and the IF/ID record.
package cpu_pkg;

   localparam int XLEN   = 32;
   localparam int INSN_W = 32;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INSN_W-1:0] instr;
      logic              pred_taken;
      logic [XLEN-1:0]   pred_target;
   } if_id_t;

   localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(3);

   // Fetch addresses are word aligned; low two bits are always cleared.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_pc_gen_if;
   import cpu_pkg::*;

   logic                imem_req;
   logic [XLEN-1:0]     imem_addr;
   logic                imem_gnt;
   logic                imem_rvalid;
   logic [INSN_W-1:0]   imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch front end: owns the fetch PC, issues single-outstanding imem requests,
// and holds each returned instruction with its BTB prediction until decode takes it.
module fetch_pc_gen
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic [XLEN-1:0]   pc_if,
   input  logic              hit_if,
   input  logic [XLEN-1:0]   target_if,
   fetch_pc_gen_if.master    imem,
   output logic              if_valid,
   output logic [XLEN-1:0]   if_pc,
   output logic [INSN_W-1:0] if_instr,
   output logic              if_pred_taken,
   output logic [XLEN-1:0]   if_pred_target,
   input  logic              id_ready,
   input  logic              redirect_en,
   input  logic [XLEN-1:0]   redirect_pc
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d;
   logic            cap_taken_q, cap_taken_d;
   logic [XLEN-1:0] cap_target_q, cap_target_d;
   if_id_t          out_q, out_d;

   logic [XLEN-1:0] pc_pred;
   logic [XLEN-1:0] redirect_aligned;

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      hold_pc_d        = hold_pc_q;
      cap_taken_d      = cap_taken_q;
      cap_target_d     = cap_target_q;
      out_d            = out_q;
      pc_pred          = hit_if ? align_pc(target_if) : (pc_q + XLEN'(4));
      redirect_aligned = align_pc(redirect_pc);

      // A redirect wins in every state; an in-flight request is turned into a drop.
      unique case (state_q)
         S_REQ: begin
            if (redirect_en) begin
               pc_d    = redirect_aligned;
               state_d = imem.imem_gnt ? S_DROP : S_REQ;
            end else if (imem.imem_gnt) begin
               hold_pc_d    = pc_q;
               cap_taken_d  = hit_if;
               cap_target_d = pc_pred;
               pc_d         = pc_pred;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_en) begin
               pc_d    = redirect_aligned;
               state_d = imem.imem_rvalid ? S_REQ : S_DROP;
            end else if (imem.imem_rvalid) begin
               out_d.pc          = hold_pc_q;
               out_d.instr       = imem.imem_rdata;
               out_d.pred_taken  = cap_taken_q;
               out_d.pred_target = cap_target_q;
               state_d           = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_en) begin
               pc_d    = redirect_aligned;
               state_d = S_REQ;
            end else if (id_ready) begin
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_en) begin
               pc_d    = redirect_aligned;
            end
            if (imem.imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_REQ;
         pc_q         <= align_pc(RESET_PC);
         hold_pc_q    <= '0;
         cap_taken_q  <= 1'b0;
         cap_target_q <= '0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_pc_q    <= hold_pc_d;
         cap_taken_q  <= cap_taken_d;
         cap_target_q <= cap_target_d;
         out_q        <= out_d;
      end
   end

   // Request is gated by reset so nothing is issued while reset is held.
   assign imem.imem_req  = rst & (state_q == S_REQ);
   assign imem.imem_addr = pc_q;
   assign pc_if          = pc_q;

   assign if_valid       = (state_q == S_HOLD);
   assign if_pc          = out_q.pc;
   assign if_instr       = out_q.instr;
   assign if_pred_taken  = out_q.pred_taken;
   assign if_pred_target = out_q.pred_target;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: transaction-level reference model plus directed scenarios.
module tb_fetch_pc_gen;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic [31:0] pc_if;
   logic        hit_if;
   logic [31:0] target_if;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        id_ready;
   logic        redirect_en;
   logic [31:0] redirect_pc;

   fetch_pc_gen_if imem ();

   fetch_pc_gen #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_if          (pc_if),
      .hit_if         (hit_if),
      .target_if      (target_if),
      .imem           (imem.master),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_pred_taken  (if_pred_taken),
      .if_pred_target (if_pred_target),
      .id_ready       (id_ready),
      .redirect_en    (redirect_en),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BTB stub: single entry, 0x108 predicts a jump to 0x200.
   function automatic logic btb_hit(input logic [31:0] pc);
      return pc == 32'h0000_0108;
   endfunction
   assign hit_if    = btb_hit(pc_if);
   assign target_if = btb_hit(pc_if) ? 32'h0000_0200 : 32'hCAFE_0000;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: at most one pending request, at most one held instruction.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        taken;
      logic [31:0] tgt;
      logic        sq;
   } rec_t;

   rec_t        pend[$];
   rec_t        held[$];
   rec_t        deliv[$];
   logic [31:0] acc_log[$];
   logic [31:0] m_pc = RST_PC;

   always @(posedge clk or negedge rst) begin : model
      logic m_req;
      rec_t r;
      if (!rst) begin
         m_pc = RST_PC;
         pend.delete();
         held.delete();
      end else begin
         m_req = (pend.size() == 0) && (held.size() == 0);
         if (redirect_en) begin
            if (pend.size() != 0) begin
               if (imem.imem_rvalid) pend.delete();
               else pend[0].sq = 1'b1;
            end else if (m_req && imem.imem_gnt) begin
               r.pc = m_pc; r.instr = '0; r.taken = 1'b0; r.tgt = '0; r.sq = 1'b1;
               pend.push_back(r);
               acc_log.push_back(m_pc);
            end
            held.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
         end else if (m_req && imem.imem_gnt) begin
            r.pc    = m_pc;
            r.instr = '0;
            r.taken = btb_hit(m_pc);
            r.tgt   = r.taken ? 32'h0000_0200 : m_pc + 32'd4;
            r.sq    = 1'b0;
            pend.push_back(r);
            acc_log.push_back(m_pc);
            m_pc = r.tgt;
         end else if (pend.size() != 0 && imem.imem_rvalid) begin
            r = pend.pop_front();
            if (!r.sq) begin
               r.instr = imem.imem_rdata;
               held.push_back(r);
            end
         end else if (held.size() != 0 && id_ready) begin
            deliv.push_back(held.pop_front());
         end
      end
   end

   // Per-cycle comparison, sampled mid-cycle between the active edge and input changes.
   always @(posedge clk) begin : compare
      logic exp_req;
      logic exp_v;
      #4;
      exp_req = rst && (pend.size() == 0) && (held.size() == 0);
      exp_v   = rst && (held.size() != 0);
      chk("imem_req", imem.imem_req, exp_req);
      chk("pc_if", pc_if, m_pc);
      chk("imem_addr", imem.imem_addr, m_pc);
      chk("if_valid", if_valid, exp_v);
      if (exp_v) begin
         chk("if_pc", if_pc, held[0].pc);
         chk("if_instr", if_instr, held[0].instr);
         chk("if_pred_taken", if_pred_taken, held[0].taken);
         chk("if_pred_target", if_pred_target, held[0].tgt);
      end
   end

   // Memory responder: rvalid arrives lat cycles after an accepted request.
   int          lat = 1;
   int          cd  = 0;
   logic [31:0] ma  = '0;
   logic        dead_en = 1'b0;

   task automatic cycle();
      logic        acc;
      logic [31:0] a;
      #1;
      acc = imem.imem_req && imem.imem_gnt;
      a   = imem.imem_addr;
      @(posedge clk);
      @(negedge clk);
      if (!rst) cd = 0;
      else if (acc) begin cd = lat; ma = a; end
      else if (cd != 0) cd--;
      imem.imem_rvalid = (cd == 1);
      imem.imem_rdata  = dead_en ? 32'h0000_DEAD : (ma ^ 32'h5A00_0000);
   endtask

   logic [31:0] pc0;
   logic [31:0] instr0;

   initial begin
      rst              = 1'b0;
      id_ready         = 1'b1;
      redirect_en      = 1'b0;
      redirect_pc      = '0;
      imem.imem_gnt    = 1'b1;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = '0;

      // Reset values
      repeat (2) cycle();
      chk("rst_req", imem.imem_req, 0);
      chk("rst_pc", pc_if, 32'h100);
      chk("rst_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_instr", if_instr, 0);
      chk("rst_taken", if_pred_taken, 0);
      chk("rst_target", if_pred_target, 0);

      // Sequential fetch and the BTB hit at 0x108
      rst = 1'b1;
      cycle();
      chk("first_req", imem.imem_req, 0);
      chk("first_addr", imem.imem_addr, 32'h104);
      repeat (11) cycle();
      chk("deliv_cnt1", deliv.size(), 4);
      if (deliv.size() >= 4) begin
         chk("d0_pc", deliv[0].pc, 32'h100);
         chk("d0_tgt", deliv[0].tgt, 32'h104);
         chk("d0_instr", deliv[0].instr, 32'h5A00_0100);
         chk("d1_pc", deliv[1].pc, 32'h104);
         chk("d1_taken", deliv[1].taken, 0);
         chk("d2_pc", deliv[2].pc, 32'h108);
         chk("d2_taken", deliv[2].taken, 1);
         chk("d2_tgt", deliv[2].tgt, 32'h200);
         chk("d3_pc", deliv[3].pc, 32'h200);
         chk("d3_tgt", deliv[3].tgt, 32'h204);
      end
      chk("addr_after_btb", imem.imem_addr, 32'h204);

      // Decode stall for 5 cycles
      id_ready = 1'b0;
      begin
         int n = 0;
         do begin cycle(); n++; end while (!if_valid && n < 10);
      end
      chk("stall_wait_valid", if_valid, 1);
      pc0    = if_pc;
      instr0 = if_instr;
      chk("stall_pc_lit", pc0, 32'h204);
      repeat (5) begin
         cycle();
         chk("stall_valid", if_valid, 1);
         chk("stall_pc", if_pc, pc0);
         chk("stall_instr", if_instr, instr0);
         chk("stall_req", imem.imem_req, 0);
      end
      id_ready = 1'b1;
      cycle();
      chk("req_after_accept", imem.imem_req, 1);
      chk("addr_after_accept", imem.imem_addr, 32'h208);

      // Redirect while waiting; the late 0xDEAD response is dropped
      lat = 3;
      cycle();
      redirect_en = 1'b1;
      redirect_pc = 32'h400;
      dead_en     = 1'b1;
      cycle();
      redirect_en = 1'b0;
      chk("wait_redir_req", imem.imem_req, 0);
      chk("wait_redir_addr", imem.imem_addr, 32'h400);
      repeat (2) cycle();
      dead_en = 1'b0;
      lat     = 1;
      chk("drop_done_req", imem.imem_req, 1);
      chk("drop_done_addr", imem.imem_addr, 32'h400);
      repeat (3) cycle();
      chk("deliv_cnt2", deliv.size(), 6);
      chk("redir_deliv_pc", deliv[$].pc, 32'h400);
      chk("redir_deliv_instr", deliv[$].instr, 32'h5A00_0400);

      // Redirect in the same cycle as a grant
      redirect_en = 1'b1;
      redirect_pc = 32'h800;
      cycle();
      redirect_en = 1'b0;
      chk("gnt_redir_req", imem.imem_req, 0);
      chk("gnt_redir_addr", imem.imem_addr, 32'h800);
      cycle();
      chk("gnt_drop_req", imem.imem_req, 1);
      chk("gnt_drop_addr", imem.imem_addr, 32'h800);
      repeat (3) cycle();
      chk("deliv_cnt3", deliv.size(), 7);
      chk("gnt_deliv_pc", deliv[$].pc, 32'h800);
      chk("acc_squashed", acc_log[acc_log.size()-2], 32'h404);

      // Asynchronous reset in the middle of a wait
      lat = 3;
      cycle();
      #3;
      rst = 1'b0;
      #1;
      chk("async_req", imem.imem_req, 0);
      chk("async_pc", pc_if, RST_PC);
      chk("async_valid", if_valid, 0);
      chk("async_if_pc", if_pc, 0);
      chk("async_instr", if_instr, 0);
      chk("async_taken", if_pred_taken, 0);
      chk("async_target", if_pred_target, 0);
      imem.imem_gnt = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      chk("post_rst_req", imem.imem_req, 1);
      chk("post_rst_addr", imem.imem_addr, RST_PC);
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = 32'h0000_0BAD;
      cycle();
      chk("stale_valid", if_valid, 0);
      chk("stale_req", imem.imem_req, 1);
      lat           = 1;
      imem.imem_gnt = 1'b1;
      repeat (3) cycle();
      chk("deliv_cnt4", deliv.size(), 8);
      chk("post_rst_deliv_pc", deliv[$].pc, RST_PC);
      chk("post_rst_deliv_instr", deliv[$].instr, 32'h5A00_0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
